sweep_ctrl: RTL and testbench



---
 rtl/sweep_pkg.sv | 26 ++
 rtl/settle_timer.sv | 33 +++
 rtl/sweep_ctrl.sv | 171 +++++++++++++++++
 tb/tb_sweep_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared types and widths for the max-voltage sweep sequencer
// Holds the FSM state encoding, the axis encoding and the data widths used by
// sweep_ctrl and its bench.
package sweep_pkg;

    localparam int ADC_W = 12;
    localparam int PW_W  = 32;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_MOVE   = 4'd1,
        S_SETTLE = 4'd2,
        S_SAMPLE = 4'd3,
        S_DECIDE = 4'd4,
        S_STEP   = 4'd5,
        S_HOLD   = 4'd6,
        S_PARK   = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    typedef enum logic {
        AXIS_H = 1'b0,
        AXIS_V = 1'b1
    } axis_t;

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - servo settle down-counter
// Ports:
//   CLK, RST : clock, asynchronous active-high reset
//   load     : (re)start the count at CYCLES
//   done     : high during the last of the CYCLES counted cycles
module settle_timer #(
    parameter int unsigned CYCLES = 2000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic load,
    output logic done
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] count;

    // Loaded on entry to SETTLE, so the first SETTLE cycle sees CYCLES and the
    // cycle seeing 1 is the last one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(CYCLES);
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign done = (count == CW'(1));

endmodule

// File: rtl/sweep_ctrl.sv
// rtl/sweep_ctrl.sv - horizontal/vertical servo sweep sequencer for max-voltage search
// Ports:
//   CLK, RST            : clock, asynchronous active-high reset
//   start               : begin a sweep (sampled only in IDLE)
//   adc_valid, adc_data : ADC sample strobe and data
//   LV                  : stored max value from the max-value register
//   pulseWidth_max_H/V  : stored best pulse widths from the register
//   pulseWidth_H/V      : servo commands, also the register's capture inputs
//   GT, PV              : capture enable and pending value to the register
//   busy, done          : sweep in progress, end-of-sweep pulse
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter logic [PW_W-1:0] PW_MIN        = 32'd100000,
    parameter logic [PW_W-1:0] PW_MAX        = 32'd200000,
    parameter logic [PW_W-1:0] PW_STEP       = 32'd10000,
    parameter logic [PW_W-1:0] PW_PARK       = 32'd150000,
    parameter int unsigned     SETTLE_CYCLES = 2000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              adc_valid,
    input  logic [ADC_W-1:0]  adc_data,
    input  logic [ADC_W-1:0]  LV,
    input  logic [PW_W-1:0]   pulseWidth_max_H,
    input  logic [PW_W-1:0]   pulseWidth_max_V,
    output logic [PW_W-1:0]   pulseWidth_H,
    output logic [PW_W-1:0]   pulseWidth_V,
    output logic              GT,
    output logic [ADC_W-1:0]  PV,
    output logic              busy,
    output logic              done
);

    state_t           state_q, state_d;
    axis_t            axis_q, axis_d;
    logic             first_q, first_d;
    logic [ADC_W-1:0] pv_q, pv_d;
    logic [PW_W-1:0]  pw_h_q, pw_h_d;
    logic [PW_W-1:0]  pw_v_q, pw_v_d;
    logic             timer_load;
    logic             timer_done;

    logic [PW_W-1:0]  pw_cur;
    logic [PW_W:0]    pw_next_wide;
    logic             step_over;

    settle_timer #(
        .CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .CLK  (CLK),
        .RST  (RST),
        .load (timer_load),
        .done (timer_done)
    );

    // One extra bit keeps pw + step from wrapping near the top of the range.
    assign pw_cur       = (axis_q == AXIS_H) ? pw_h_q : pw_v_q;
    assign pw_next_wide = {1'b0, pw_cur} + {1'b0, PW_STEP};
    assign step_over    = (pw_next_wide > {1'b0, PW_MAX});

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            axis_q  <= AXIS_H;
            first_q <= 1'b0;
            pv_q    <= '0;
            pw_h_q  <= PW_PARK;
            pw_v_q  <= PW_PARK;
        end else begin
            state_q <= state_d;
            axis_q  <= axis_d;
            first_q <= first_d;
            pv_q    <= pv_d;
            pw_h_q  <= pw_h_d;
            pw_v_q  <= pw_v_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        axis_d     = axis_q;
        first_d    = first_q;
        pv_d       = pv_q;
        pw_h_d     = pw_h_q;
        pw_v_d     = pw_v_q;
        timer_load = 1'b0;
        GT         = 1'b0;
        busy       = (state_q != S_IDLE);
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    axis_d     = AXIS_H;
                    pw_h_d     = PW_MIN;
                    first_d    = 1'b1;
                    timer_load = 1'b1;
                    state_d    = S_SETTLE;
                end
            end
            // Not entered by the sweep itself; behaves as a plain settle entry.
            S_MOVE: begin
                timer_load = 1'b1;
                state_d    = S_SETTLE;
            end
            S_SETTLE: begin
                if (timer_done) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (adc_valid) begin
                    pv_d    = adc_data;
                    state_d = S_DECIDE;
                end
            end
            // Strict compare: a tie keeps the earlier point. The first point of
            // a sweep always captures, overriding whatever the register holds.
            S_DECIDE: begin
                GT      = first_q || (pv_q > LV);
                first_d = 1'b0;
                state_d = S_STEP;
            end
            S_STEP: begin
                if (step_over) begin
                    state_d = S_HOLD;
                end else begin
                    if (axis_q == AXIS_H) begin
                        pw_h_d = pw_next_wide[PW_W-1:0];
                    end else begin
                        pw_v_d = pw_next_wide[PW_W-1:0];
                    end
                    timer_load = 1'b1;
                    state_d    = S_SETTLE;
                end
            end
            // One cycle after the last GT so the register's best H is visible.
            // first stays clear: V points compete against the H maximum.
            S_HOLD: begin
                if (axis_q == AXIS_H) begin
                    pw_h_d     = pulseWidth_max_H;
                    axis_d     = AXIS_V;
                    pw_v_d     = PW_MIN;
                    timer_load = 1'b1;
                    state_d    = S_SETTLE;
                end else begin
                    state_d = S_PARK;
                end
            end
            S_PARK: begin
                pw_h_d  = pulseWidth_max_H;
                pw_v_d  = pulseWidth_max_V;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pulseWidth_H = pw_h_q;
    assign pulseWidth_V = pw_v_q;
    assign PV           = pv_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb/tb_sweep_ctrl.sv - self-checking bench for sweep_ctrl with a max-value register model
module tb_sweep_ctrl;
    import sweep_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST;
    logic        start_a, start_b, start_c;
    logic        adc_valid;
    logic [11:0] adc_data;

    logic [11:0] lv_a = '0, lv_b = '0, lv_c = '0;
    logic [31:0] mh_a = '0, mh_b = '0, mh_c = '0;
    logic [31:0] mv_a = '0, mv_b = '0, mv_c = '0;
    logic [31:0] pwh_a, pwh_b, pwh_c, pwv_a, pwv_b, pwv_c;
    logic [11:0] pv_a, pv_b, pv_c;
    logic        gt_a, gt_b, gt_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;

    sweep_ctrl #(.PW_MIN(32'd100), .PW_MAX(32'd200), .PW_STEP(32'd50), .PW_PARK(32'd150), .SETTLE_CYCLES(4)) dut_a (
        .CLK(CLK), .RST(RST), .start(start_a), .adc_valid(adc_valid), .adc_data(adc_data),
        .LV(lv_a), .pulseWidth_max_H(mh_a), .pulseWidth_max_V(mv_a),
        .pulseWidth_H(pwh_a), .pulseWidth_V(pwv_a), .GT(gt_a), .PV(pv_a), .busy(busy_a), .done(done_a));

    sweep_ctrl #(.PW_MIN(32'd100), .PW_MAX(32'd220), .PW_STEP(32'd50), .PW_PARK(32'd150), .SETTLE_CYCLES(4)) dut_b (
        .CLK(CLK), .RST(RST), .start(start_b), .adc_valid(adc_valid), .adc_data(adc_data),
        .LV(lv_b), .pulseWidth_max_H(mh_b), .pulseWidth_max_V(mv_b),
        .pulseWidth_H(pwh_b), .pulseWidth_V(pwv_b), .GT(gt_b), .PV(pv_b), .busy(busy_b), .done(done_b));

    sweep_ctrl #(.PW_MIN(32'd100), .PW_MAX(32'd100), .PW_STEP(32'd50), .PW_PARK(32'd150), .SETTLE_CYCLES(4)) dut_c (
        .CLK(CLK), .RST(RST), .start(start_c), .adc_valid(adc_valid), .adc_data(adc_data),
        .LV(lv_c), .pulseWidth_max_H(mh_c), .pulseWidth_max_V(mv_c),
        .pulseWidth_H(pwh_c), .pulseWidth_V(pwv_c), .GT(gt_c), .PV(pv_c), .busy(busy_c), .done(done_c));

    // Max-value register models: capture on GT, never cleared by RST.
    always @(posedge CLK) begin
        if (gt_a) begin lv_a <= pv_a; mh_a <= pwh_a; mv_a <= pwv_a; end
        if (gt_b) begin lv_b <= pv_b; mh_b <= pwh_b; mv_b <= pwv_b; end
        if (gt_c) begin lv_c <= pv_c; mh_c <= pwh_c; mv_c <= pwv_c; end
    end

    int          sel;
    state_t      cur_state;
    logic        cur_gt, cur_busy;
    logic [31:0] cur_pwh, cur_pwv;
    logic [11:0] cur_pv, cur_lv;

    always_comb begin
        cur_state = dut_a.state_q; cur_gt = gt_a; cur_busy = busy_a;
        cur_pwh = pwh_a; cur_pwv = pwv_a; cur_pv = pv_a; cur_lv = lv_a;
        if (sel == 1) begin
            cur_state = dut_b.state_q; cur_gt = gt_b; cur_busy = busy_b;
            cur_pwh = pwh_b; cur_pwv = pwv_b; cur_pv = pv_b; cur_lv = lv_b;
        end else if (sel == 2) begin
            cur_state = dut_c.state_q; cur_gt = gt_c; cur_busy = busy_c;
            cur_pwh = pwh_c; cur_pwv = pwv_c; cur_pv = pv_c; cur_lv = lv_c;
        end
    end

    int   done_cnt = 0, gt_cnt = 0, gt_viol = 0;
    logic gp_a = 1'b0, gp_b = 1'b0, gp_c = 1'b0;

    always @(negedge CLK) begin
        done_cnt = done_cnt + int'(done_a) + int'(done_b) + int'(done_c);
        gt_cnt   = gt_cnt + int'(gt_a) + int'(gt_b) + int'(gt_c);
        if ((gt_a && gp_a) || (gt_b && gp_b) || (gt_c && gp_c)) gt_viol = gt_viol + 1;
        gp_a = gt_a; gp_b = gt_b; gp_c = gt_c;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input logic val);
        case (sel)
            1:       start_b = val;
            2:       start_c = val;
            default: start_a = val;
        endcase
    endtask

    typedef struct {
        string            name;
        int               sel;
        int               npts;
        logic [5:0][11:0] s;
        logic [5:0]       mask;
        int               park_h;
        int               park_v;
        int               lv;
        bit               inj_start;
        bit               inj_adc;
    } vec_t;

    function automatic vec_t mk(string name, int dsel, int npts,
                                int s0, int s1, int s2, int s3, int s4, int s5,
                                logic [5:0] mask, int h, int v, int lv, bit is, bit ia);
        vec_t r;
        r.name = name; r.sel = dsel; r.npts = npts;
        r.s[0] = 12'(s0); r.s[1] = 12'(s1); r.s[2] = 12'(s2);
        r.s[3] = 12'(s3); r.s[4] = 12'(s4); r.s[5] = 12'(s5);
        r.mask = mask; r.park_h = h; r.park_v = v; r.lv = lv;
        r.inj_start = is; r.inj_adc = ia;
        return r;
    endfunction

    task automatic run_vec(input vec_t v);
        logic [5:0] mask;
        int         done_base, gt_base, pos_err, pv_err, cyc, idx;
        longint     pw;
        sel       = v.sel;
        mask      = '0;
        pos_err   = 0;
        pv_err    = 0;
        done_base = done_cnt;
        gt_base   = gt_cnt;
        @(negedge CLK); set_start(1'b1);
        @(negedge CLK); set_start(1'b0);
        check({v.name, "_busy_after_start"}, cur_busy, 1);
        for (int k = 0; k < 2 * v.npts; k++) begin
            cyc = 0;
            while (cur_state != S_SAMPLE && cyc < 500) begin
                adc_valid = (v.inj_adc && k == 0 && cur_state == S_SETTLE);
                adc_data  = 12'd999;
                set_start(v.inj_start && k == 0 && cur_state == S_SETTLE);
                @(negedge CLK);
                cyc++;
            end
            adc_valid = 1'b0;
            set_start(1'b0);
            if (cyc >= 500) begin
                check({v.name, "_sample_timeout"}, k, -1);
                return;
            end
            if (v.inj_start && k == 0) begin
                set_start(1'b1);
                @(negedge CLK);
                set_start(1'b0);
            end
            if (v.inj_adc && k == 0) begin
                repeat (100) @(negedge CLK);
                check({v.name, "_waits_in_sample"}, cur_state, S_SAMPLE);
            end
            adc_valid = 1'b1;
            adc_data  = v.s[k];
            @(negedge CLK);
            adc_valid = 1'b0;
            if (cur_state != S_DECIDE) pos_err++;
            mask[k] = cur_gt;
            if (cur_pv !== v.s[k]) pv_err++;
            idx = k % v.npts;
            pw  = (k < v.npts) ? longint'(cur_pwh) : longint'(cur_pwv);
            if (pw != 100 + 50 * idx) pos_err++;
        end
        cyc = 0;
        while (done_cnt == done_base && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
        repeat (4) @(negedge CLK);
        check({v.name, "_done_pulses"}, done_cnt - done_base, 1);
        check({v.name, "_gt_mask"}, mask, v.mask);
        check({v.name, "_gt_total"}, gt_cnt - gt_base, $countones(v.mask));
        check({v.name, "_positions"}, pos_err, 0);
        check({v.name, "_pv"}, pv_err, 0);
        check({v.name, "_park_h"}, cur_pwh, v.park_h);
        check({v.name, "_park_v"}, cur_pwv, v.park_v);
        check({v.name, "_lv"}, cur_lv, v.lv);
        check({v.name, "_idle_busy"}, cur_busy, 0);
        check({v.name, "_idle_state"}, cur_state, S_IDLE);
    endtask

    vec_t vecs[6];
    vec_t v_rst;
    int   cyc;

    initial begin
        vecs[0] = mk("hv_basic",      0, 3,  10,  30,  20,   5,  40,  35, 6'b010011, 150, 150,  40, 0, 0);
        vecs[1] = mk("all_equal",     0, 3, 500, 500, 500, 500, 500, 500, 6'b000001, 100, 150, 500, 0, 0);
        vecs[2] = mk("start_ignored", 0, 3, 600, 601, 602, 603, 604, 605, 6'b111111, 200, 200, 605, 1, 0);
        vecs[3] = mk("late_adc",      0, 3,  77,   1,   1,   1,   1,   1, 6'b000001, 100, 200,  77, 0, 1);
        vecs[4] = mk("unaligned_max", 1, 3,  10,  20,  30,  40,  50,  60, 6'b111111, 200, 200,  60, 0, 0);
        vecs[5] = mk("single_point",  2, 1,   4,   9,   0,   0,   0,   0, 6'b000011, 100, 100,   9, 0, 0);
        v_rst   = mk("reset_resweep", 0, 3,   3,   3,   3,   3,   3,   3, 6'b000001, 100, 150,   3, 0, 0);

        sel = 0;
        RST = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        adc_valid = 1'b0; adc_data = '0;
        repeat (3) @(negedge CLK);
        check("reset_pw_h", pwh_a, 150);
        check("reset_pw_v", pwv_a, 150);
        check("reset_gt", gt_a, 0);
        check("reset_pv", pv_a, 0);
        check("reset_busy", busy_a, 0);
        check("reset_done", done_a, 0);
        RST = 1'b0;
        @(negedge CLK);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the middle of point 2's settle, then re-sweep against a stale LV.
        sel = 0;
        @(negedge CLK); start_a = 1'b1;
        @(negedge CLK); start_a = 1'b0;
        cyc = 0;
        while (cur_state != S_SAMPLE && cyc < 500) begin @(negedge CLK); cyc++; end
        adc_valid = 1'b1; adc_data = 12'd900;
        @(negedge CLK); adc_valid = 1'b0;
        check("rst_first_point_gt", gt_a, 1);
        cyc = 0;
        while (cur_state != S_SETTLE && cyc < 500) begin @(negedge CLK); cyc++; end
        repeat (2) @(negedge CLK);
        check("rst_pre_pw_v", pwv_a, 200);
        RST = 1'b1;
        #1;
        check("rst_async_pw_h", pwh_a, 150);
        check("rst_async_pw_v", pwv_a, 150);
        check("rst_async_busy", busy_a, 0);
        check("rst_async_gt", gt_a, 0);
        @(negedge CLK);
        RST = 1'b0;
        run_vec(v_rst);

        check("gt_never_back_to_back", gt_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
